coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Bus-side coherence controller and memory arbiter for the dual-core system. It sits between the two cores' cache pairs (icache/dcache, index 0 and 1) and the single RAM port. It serialises fetches, coherent reads, writebacks and invalidations. It drives the snoop handshake (`ccwait`/`ccinv`/`ccsnoopaddr`) into the non-requesting dcache and services that cache's dirty-line writeback before releasing the requester.

## Interface
- `CPUS`, default 2: number of cache pairs; fixed at 2, with one round-robin bit.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `iREN[CPUS]` in 1: icache read request.
- `iaddr[CPUS]` in 32: icache word address.
- `iwait[CPUS]` out 1: icache stall; 0 for one cycle when `iload` is valid.
- `iload[CPUS]` out 32: fetched word.
- `dREN[CPUS]`, `dWEN[CPUS]` in 1: dcache read and write requests.
- `daddr[CPUS]` in 32: dcache word address.
- `dstore[CPUS]` in 32: dcache write data.
- `cctrans[CPUS]` in 1: coherent transaction / snoop acknowledge.
- `ccwrite[CPUS]` in 1: exclusive intent (requester) or dirty hit (snooper).
- `dwait[CPUS]` out 1: dcache stall; 0 for one cycle per completed word.
- `dload[CPUS]` out 32: loaded word.
- `ccwait[CPUS]` out 1: snoop request to this dcache.
- `ccinv[CPUS]` out 1: invalidate on snoop hit.
- `ccsnoopaddr[CPUS]` out 32: snooped address.
- `ramstate` in `ramstate_t`: FREE/BUSY/ACCESS/ERROR.
- `ramload` in 32: RAM read data.
- `ramREN`, `ramWEN` out 1: RAM strobes, never both high.
- `ramaddr` out 32, `ramstore` out 32: RAM address and write data.

## Operation
- Request classes, per dcache `c`:
  - INV: `cctrans & !dREN & !dWEN`. One-cycle pulse from a write hit on a clean line. It is latched into `inv_pend[c]` and `inv_addr[c]` the same cycle.
  - CRD: `cctrans & dREN`, a coherent read miss. `ccwrite` high means read-for-ownership.
  - WB: `dWEN & !cctrans`, an eviction or flush writeback. No snoop.
  - IF: `iREN`.
- Priority, evaluated in IDLE: pending INV, then WB, then CRD, then IF.
  - Ties between caches go to `!last_grant`.
  - `last_grant` toggles on every dcache grant.
- States:
  - IDLE: arbitrates, moves to INVAL, WB, SNOOP or IFETCH.
  - INVAL: `ccwait[o]=1`, `ccinv[o]=1`, `ccsnoopaddr[o]=inv_addr[c]`. Waits for `cctrans[o]`, then clears `inv_pend[c]` and goes to IDLE.
  - SNOOP: `ccwait[o]=1`, `ccsnoopaddr[o]=daddr[c]`, `ccinv[o]=ccwrite[c]`. On `cctrans[o]`: with `ccwrite[o]` go to CCWB, otherwise go to DATA.
  - CCWB: RAM write of `dstore[o]`/`daddr[o]` while `dWEN[o]`. `dwait[o]=!(ramstate==ACCESS)`. `ccwait[o]` is held. After the second word, go to DATA.
  - DATA: requester `c` is connected to RAM (`ramREN=dREN[c]`, `ramaddr=daddr[c]`, `dload[c]=ramload`). `dwait[c]=!(ramstate==ACCESS)`. After the second ACCESS, go to IDLE.
  - WB: the same pass-through with `ramWEN`, for two words, then IDLE.
  - IFETCH: single word, `iwait=!(ramstate==ACCESS)`, then IDLE.
- `o` is the other cache index (`!c`).
- Word count: one counter bit, cleared on entry to each multi-word state.
- `ramstate==ERROR`: treated as BUSY; no progress is made and the request is retried.
- A requester dropping its request mid-DATA or mid-WB (a dcache re-snooped while in LD1) returns the controller to IDLE. Partial words are discarded.
- INV arriving while busy: latched and serviced next IDLE. A second INV from the same cache before service overwrites `inv_addr`.

## Timing
- Reset values: `iwait`=1, `dwait`=1, `ccwait`=0, `ccinv`=0, `ccsnoopaddr`=0, `iload`=0, `dload`=0, `ramREN`=0, `ramWEN`=0, `ramaddr`=0, `ramstore`=0, state IDLE, `inv_pend`=0, `last_grant`=0.
- Reset mid-transaction aborts at the next edge.
- Grant latency: the state changes the cycle after the request is seen in IDLE. All outputs are Moore-registered state decodes plus combinational pass-through.
- `ccwait` rises the first cycle of SNOOP/INVAL. The snooper acknowledges no earlier than +1 cycle. `ccwait` falls the cycle after acknowledge, or after the second CCWB word.
- Zero-wait RAM, clean snoop: CRD completes in 1 (grant) + 2 (snoop) + 2 (words) = 5 cycles.

## Configuration
- `C2C_XFER_EN` defined: during CCWB, `dload[c]=dstore[o]` and `dwait[c]` mirrors `dwait[o]`. The requester is filled cache-to-cache, and the controller returns to IDLE, skipping DATA.
- `C2C_XFER_EN` undefined: the requester always reloads from RAM in DATA after the writeback.

## Structure
- `cpu_types_pkg`: `word_t`, `ramstate_t`.
- `diaosi_types_pkg`: `busstate_t` (IDLE, INVAL, SNOOP, CCWB, DATA, WB, IFETCH) and the `reqclass_t` enum.
- Sub-module `bus_arbiter`: priority plus round-robin selection. It outputs the grant index and class.

## Test plan
- Cache0 `iREN=1`, `iaddr=0x100`, ramload `0xDEADBEEF`, zero wait → `iwait[0]=0` for one cycle with `iload[0]=0xDEADBEEF`; `ramWEN` stays 0.
- Cache1 CRD at `0x40`, cache0 clean → `ccwait[0]=1`, `ccsnoopaddr[0]=0x40`, `ccinv[0]=0`. After cache0 acknowledges with `ccwrite=0`: two RAM reads at 0x40/0x44, and `dwait[1]` low twice.
- Cache1 CRD with `ccwrite=1`, cache0 dirty → `ccinv[0]=1`; RAM writes of cache0 data at 0x40/0x44; then cache1 load.
  - Without `C2C_XFER_EN`: the cache1 load comes from RAM.
  - With `C2C_XFER_EN`: `dload[1]` equals cache0 `dstore`.
- Simultaneous WB from both caches with `last_grant=0` → cache1 is served first, then cache0. `last_grant` ends at 0.
- INV pulse from cache0 at `0x80` during a cache1 WB → the WB completes, then INVAL with `ccinv[1]=1` and `ccsnoopaddr[1]=0x80`; `inv_pend` clears.
- `nRST=0` asserted mid-CCWB → next edge gives IDLE, `ccwait=0`, `ramWEN=0`, `dwait`=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
//==============================================================================
// cpu_types_pkg: shared CPU word and RAM handshake types.  Rev 1.0
//==============================================================================
`default_nettype none

package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

`default_nettype wire

// File: rtl/diaosi_types_pkg.sv
//==============================================================================
// diaosi_types_pkg: bus controller states, request classes, tie-break helper.  Rev 1.0
//==============================================================================
`default_nettype none

package diaosi_types_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INVAL  = 3'd1,
    SNOOP  = 3'd2,
    CCWB   = 3'd3,
    DATA   = 3'd4,
    WB     = 3'd5,
    IFETCH = 3'd6
  } busstate_t;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_INV  = 3'd1,
    REQ_WB   = 3'd2,
    REQ_CRD  = 3'd3,
    REQ_IF   = 3'd4
  } reqclass_t;

  // Both caches requesting: the one not granted last wins.
  function automatic logic pick_idx(input logic [1:0] req, input logic last_grant);
    return (req == 2'b11) ? ~last_grant : req[1];
  endfunction
endpackage

`default_nettype wire

// File: rtl/bus_arbiter.sv
//==============================================================================
// bus_arbiter: class priority (INV > WB > CRD > IF) with round-robin tie-break.  Rev 1.0
//==============================================================================
`default_nettype none

module bus_arbiter
  import diaosi_types_pkg::*;
(
  input  logic [1:0] inv_pend,
  input  logic [1:0] wb_req,
  input  logic [1:0] crd_req,
  input  logic [1:0] if_req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx,
  output reqclass_t  gnt_class
);

  always_comb begin
    gnt_valid = 1'b1;
    gnt_idx   = 1'b0;
    gnt_class = REQ_NONE;
    if (|inv_pend) begin
      gnt_class = REQ_INV;
      gnt_idx   = pick_idx(inv_pend, last_grant);
    end else if (|wb_req) begin
      gnt_class = REQ_WB;
      gnt_idx   = pick_idx(wb_req, last_grant);
    end else if (|crd_req) begin
      gnt_class = REQ_CRD;
      gnt_idx   = pick_idx(crd_req, last_grant);
    end else if (|if_req) begin
      gnt_class = REQ_IF;
      gnt_idx   = pick_idx(if_req, last_grant);
    end else begin
      gnt_valid = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coherence_bus_ctrl.sv
//==============================================================================
// coherence_bus_ctrl: dual-core snoop/RAM bus controller; C2C_XFER_EN enables cache-to-cache fill.
// Rev 1.0
//==============================================================================
`default_nettype none

module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr [CPUS],
  output logic [CPUS-1:0] iwait,
  output word_t           iload [CPUS],
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           daddr [CPUS],
  input  word_t           dstore [CPUS],
  input  logic [CPUS-1:0] cctrans,
  input  logic [CPUS-1:0] ccwrite,
  output logic [CPUS-1:0] dwait,
  output word_t           dload [CPUS],
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output word_t           ccsnoopaddr [CPUS],
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore
);

  busstate_t       state, state_n;
  logic            gnt, gnt_n, cnt, cnt_n, last_grant, last_grant_n;
  logic [CPUS-1:0] inv_pend, inv_set, inv_clr;
  word_t           inv_addr [CPUS];
  logic            oth, acc;
  logic            arb_valid, arb_idx;
  reqclass_t       arb_class;

  assign oth = ~gnt;
  assign acc = (ramstate == ACCESS);
  // A snooped cache acknowledges with the same encoding as an INV pulse; exclude it.
  assign inv_set = cctrans & ~dREN & ~dWEN & ~ccwait;

  bus_arbiter u_arb (
    .inv_pend   (inv_pend),
    .wb_req     (dWEN & ~cctrans),
    .crd_req    (cctrans & dREN),
    .if_req     (iREN),
    .last_grant (last_grant),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx),
    .gnt_class  (arb_class)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      cnt        <= 1'b0;
      last_grant <= 1'b0;
      inv_pend   <= '0;
      for (int i = 0; i < CPUS; i++) inv_addr[i] <= '0;
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      for (int i = 0; i < CPUS; i++) begin
        if (inv_set[i]) begin
          inv_pend[i] <= 1'b1;
          inv_addr[i] <= daddr[i];
        end else if (inv_clr[i]) begin
          inv_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    inv_clr      = '0;
    unique case (state)
      IDLE: if (arb_valid) begin
        gnt_n = arb_idx;
        cnt_n = 1'b0;
        if (arb_class != REQ_IF) last_grant_n = ~last_grant;
        case (arb_class)
          REQ_INV: state_n = INVAL;
          REQ_WB:  state_n = WB;
          REQ_CRD: state_n = SNOOP;
          REQ_IF:  state_n = IFETCH;
          default: state_n = IDLE;
        endcase
      end
      INVAL: if (cctrans[oth]) begin
        inv_clr[gnt] = 1'b1;
        state_n      = IDLE;
      end
      SNOOP: if (cctrans[oth]) begin
        cnt_n   = 1'b0;
        state_n = ccwrite[oth] ? CCWB : DATA;
      end
      CCWB: if (acc && dWEN[oth]) begin
        cnt_n = ~cnt;
`ifdef C2C_XFER_EN
        if (cnt) state_n = IDLE;
`else
        if (cnt) state_n = DATA;
`endif
      end
      DATA: if (!dREN[gnt]) begin
        state_n = IDLE;
      end else if (acc) begin
        cnt_n = ~cnt;
        if (cnt) state_n = IDLE;
      end
      WB: if (!dWEN[gnt]) begin
        state_n = IDLE;
      end else if (acc) begin
        cnt_n = ~cnt;
        if (cnt) state_n = IDLE;
      end
      IFETCH: if (!iREN[gnt] || acc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    iload       = '{default: '0};
    dload       = '{default: '0};
    ccsnoopaddr = '{default: '0};
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state)
      INVAL: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = 1'b1;
        ccsnoopaddr[oth] = inv_addr[gnt];
      end
      SNOOP: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = ccwrite[gnt];
        ccsnoopaddr[oth] = daddr[gnt];
      end
      CCWB: begin
        ccwait[oth]      = 1'b1;
        ccinv[oth]       = ccwrite[gnt];
        ccsnoopaddr[oth] = daddr[gnt];
        ramWEN           = dWEN[oth];
        ramaddr          = daddr[oth];
        ramstore         = dstore[oth];
        dwait[oth]       = ~acc;
`ifdef C2C_XFER_EN
        dload[gnt]       = dstore[oth];
        dwait[gnt]       = ~acc;
`endif
      end
      DATA: begin
        ramREN     = dREN[gnt];
        ramaddr    = daddr[gnt];
        dload[gnt] = ramload;
        dwait[gnt] = ~acc;
      end
      WB: begin
        ramWEN     = dWEN[gnt];
        ramaddr    = daddr[gnt];
        ramstore   = dstore[gnt];
        dwait[gnt] = ~acc;
      end
      IFETCH: begin
        ramREN     = iREN[gnt];
        ramaddr    = iaddr[gnt];
        iload[gnt] = ramload;
        iwait[gnt] = ~acc;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
//==============================================================================
// tb_coherence_bus_ctrl: directed self-checking bench for coherence_bus_ctrl.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

  logic       CLK, nRST;
  logic [1:0] iREN, iwait, dREN, dWEN, cctrans, ccwrite, dwait, ccwait, ccinv;
  word_t      iaddr [2], iload [2], daddr [2], dstore [2], dload [2], ccsnoopaddr [2];
  ramstate_t  ramstate;
  word_t      ramload, ramaddr, ramstore;
  logic       ramREN, ramWEN;
  int         checks = 0;
  int         failures = 0;

  coherence_bus_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '{default: '0}; daddr = '{default: '0}; dstore = '{default: '0};
    ramstate = FREE; ramload = '0;

    // Reset state
    tick; tick;
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ccwait", 32'(ccwait), 32'h0);
    chk("rst_ccinv", 32'(ccinv), 32'h0);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramWEN", 32'(ramWEN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_snoopaddr0", ccsnoopaddr[0], 32'h0);
    chk("rst_dload1", dload[1], 32'h0);
    chk("rst_last_grant", 32'(dut.last_grant), 32'h0);
    chk("rst_inv_pend", 32'(dut.inv_pend), 32'h0);

    // Instruction fetch, cache0, zero wait
    nRST = 1'b1; iREN[0] = 1'b1; iaddr[0] = 32'h100; ramload = 32'hDEADBEEF;
    settle;
    chk("if_idle_iwait", 32'(iwait), 32'h3);
    tick;
    ramstate = ACCESS;
    settle;
    chk("if_ramREN", 32'(ramREN), 32'h1);
    chk("if_ramaddr", ramaddr, 32'h100);
    chk("if_iwait", 32'(iwait), 32'h2);
    chk("if_iload0", iload[0], 32'hDEADBEEF);
    chk("if_ramWEN", 32'(ramWEN), 32'h0);
    tick;
    iREN = '0; ramstate = FREE;
    settle;
    chk("if_done_iwait", 32'(iwait), 32'h3);
    chk("if_done_iload0", iload[0], 32'h0);

    // Coherent read from cache1, cache0 clean
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b0; daddr[1] = 32'h40;
    tick;
    chk("crd_ccwait", 32'(ccwait), 32'h1);
    chk("crd_snoopaddr0", ccsnoopaddr[0], 32'h40);
    chk("crd_ccinv", 32'(ccinv), 32'h0);
    chk("crd_snoop_dwait", 32'(dwait), 32'h3);
    cctrans[0] = 1'b1; ccwrite[0] = 1'b0;
    tick;
    cctrans[0] = 1'b0; ramstate = ACCESS; ramload = 32'h11111111;
    settle;
    chk("crd_w0_ramREN", 32'(ramREN), 32'h1);
    chk("crd_w0_ramaddr", ramaddr, 32'h40);
    chk("crd_w0_dwait", 32'(dwait), 32'h1);
    chk("crd_w0_dload1", dload[1], 32'h11111111);
    chk("crd_w0_ccwait", 32'(ccwait), 32'h0);
    tick;
    daddr[1] = 32'h44; ramload = 32'h22222222;
    settle;
    chk("crd_w1_ramaddr", ramaddr, 32'h44);
    chk("crd_w1_dwait", 32'(dwait), 32'h1);
    chk("crd_w1_dload1", dload[1], 32'h22222222);
    tick;
    dREN = '0; cctrans = '0; ramstate = FREE;
    settle;
    chk("crd_done_dwait", 32'(dwait), 32'h3);
    chk("crd_done_ramREN", 32'(ramREN), 32'h0);
    chk("crd_done_state", 32'(dut.state), 32'(IDLE));

    // Read-for-ownership from cache1, cache0 dirty
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h40;
    tick;
    chk("rfo_ccinv", 32'(ccinv), 32'h1);
    chk("rfo_ccwait", 32'(ccwait), 32'h1);
    tick;
    chk("rfo_wait_state", 32'(dut.state), 32'(SNOOP));
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h40; dstore[0] = 32'hAAAA0001;
    tick;
    cctrans[0] = 1'b0; ramstate = ACCESS;
    settle;
    chk("ccwb_w0_ramWEN", 32'(ramWEN), 32'h1);
    chk("ccwb_w0_ramREN", 32'(ramREN), 32'h0);
    chk("ccwb_w0_ramaddr", ramaddr, 32'h40);
    chk("ccwb_w0_ramstore", ramstore, 32'hAAAA0001);
    chk("ccwb_w0_ccwait", 32'(ccwait), 32'h1);
`ifdef C2C_XFER_EN
    chk("ccwb_w0_dwait", 32'(dwait), 32'h0);
    chk("c2c_w0_dload1", dload[1], 32'hAAAA0001);
`else
    chk("ccwb_w0_dwait", 32'(dwait), 32'h2);
`endif
    tick;
    daddr[0] = 32'h44; dstore[0] = 32'hAAAA0002;
    settle;
    chk("ccwb_w1_ramaddr", ramaddr, 32'h44);
    chk("ccwb_w1_ramstore", ramstore, 32'hAAAA0002);
`ifdef C2C_XFER_EN
    chk("c2c_w1_dload1", dload[1], 32'hAAAA0002);
`endif
    tick;
    dWEN[0] = 1'b0; ccwrite[0] = 1'b0;
`ifdef C2C_XFER_EN
    settle;
    chk("c2c_skip_data", 32'(dut.state), 32'(IDLE));
`else
    ramload = 32'h33333333;
    settle;
    chk("rfo_d0_ramREN", 32'(ramREN), 32'h1);
    chk("rfo_d0_ramWEN", 32'(ramWEN), 32'h0);
    chk("rfo_d0_ramaddr", ramaddr, 32'h40);
    chk("rfo_d0_dload1", dload[1], 32'h33333333);
    chk("rfo_d0_ccwait", 32'(ccwait), 32'h0);
    tick;
    daddr[1] = 32'h44; ramload = 32'h44444444;
    settle;
    chk("rfo_d1_dload1", dload[1], 32'h44444444);
    chk("rfo_d1_dwait", 32'(dwait), 32'h1);
    tick;
`endif
    dREN = '0; cctrans = '0; ccwrite = '0; ramstate = FREE;
    settle;
    chk("rfo_done_state", 32'(dut.state), 32'(IDLE));
    chk("rfo_done_dwait", 32'(dwait), 32'h3);

    // Simultaneous writebacks with last_grant=0: cache1 first
    chk("wb_pre_last_grant", 32'(dut.last_grant), 32'h0);
    dWEN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
    dstore[0] = 32'hC0C0C0C0; dstore[1] = 32'hD1D1D1D1;
    tick;
    ramstate = ACCESS;
    settle;
    chk("wb1_ramaddr", ramaddr, 32'h300);
    chk("wb1_ramstore", ramstore, 32'hD1D1D1D1);
    chk("wb1_dwait", 32'(dwait), 32'h1);
    tick; tick;
    dWEN[1] = 1'b0; ramstate = FREE;
    settle;
    chk("wb_gap_ramWEN", 32'(ramWEN), 32'h0);
    tick;
    ramstate = ACCESS;
    settle;
    chk("wb0_ramaddr", ramaddr, 32'h200);
    chk("wb0_ramstore", ramstore, 32'hC0C0C0C0);
    chk("wb0_dwait", 32'(dwait), 32'h2);
    tick; tick;
    dWEN = '0; ramstate = FREE;
    settle;
    chk("wb_last_grant", 32'(dut.last_grant), 32'h0);
    chk("wb_done_state", 32'(dut.state), 32'(IDLE));

    // INV pulse from cache0 during a cache1 writeback
    dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 32'h12345678;
    tick;
    cctrans[0] = 1'b1; daddr[0] = 32'h80; ramstate = ACCESS;
    settle;
    chk("inv_pre_pend", 32'(dut.inv_pend), 32'h0);
    tick;
    cctrans[0] = 1'b0;
    settle;
    chk("inv_latched", 32'(dut.inv_pend), 32'h1);
    chk("inv_wb_busy", 32'(ramWEN), 32'h1);
    chk("inv_wb_addr", ramaddr, 32'h300);
    tick;
    dWEN = '0; ramstate = FREE;
    settle;
    chk("inv_idle_ccwait", 32'(ccwait), 32'h0);
    tick;
    chk("inval_ccwait", 32'(ccwait), 32'h2);
    chk("inval_ccinv", 32'(ccinv), 32'h2);
    chk("inval_snoopaddr1", ccsnoopaddr[1], 32'h80);
    cctrans[1] = 1'b1;
    tick;
    cctrans[1] = 1'b0;
    settle;
    chk("inval_cleared", 32'(dut.inv_pend), 32'h0);
    chk("inval_done_ccwait", 32'(ccwait), 32'h0);

    // Reset mid-CCWB, with RAM stalled and then erroring
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h40;
    tick;
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h40; dstore[0] = 32'h5;
    tick;
    cctrans[0] = 1'b0;
    settle;
    chk("stall_ccwb_ramWEN", 32'(ramWEN), 32'h1);
    chk("stall_ccwb_dwait", 32'(dwait), 32'h3);
    ramstate = ERROR;
    tick;
    chk("err_state", 32'(dut.state), 32'(CCWB));
    chk("err_dwait", 32'(dwait), 32'h3);
    nRST = 1'b0;
    tick;
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_ccwait", 32'(ccwait), 32'h0);
    chk("abort_ramWEN", 32'(ramWEN), 32'h0);
    chk("abort_dwait", 32'(dwait), 32'h3);
    nRST = 1'b1; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = FREE;
    tick;
    chk("post_abort_state", 32'(dut.state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
